counter_3bit: RTL and testbench

//  Free-running 3-bit synchronous binary counter with bit-sliced outputs Q2 (MSB), Q1, Q0 (LSB).

---
 rtl/counter_3bit.sv | 45 ++++
 tb/tb_counter_3bit.sv | 117 +++++++++++
 2 files changed

// File: rtl/counter_3bit.sv
// Free-running 3-bit synchronous counter with bit-sliced registered outputs.
// Modulus and direction are set by parameters. Any out-of-range state falls back to zero.
module counter_3bit #(
    parameter logic [2:0] RESET_VALUE = 3'd0,
    parameter int         MODULUS     = 8,
    parameter bit         COUNT_DOWN  = 1'b0
) (
    input  logic clk,
    input  logic rst,
    output logic Q2,
    output logic Q1,
    output logic Q0
);

    localparam logic [2:0] MAX_COUNT = 3'(MODULUS - 1);

    logic [2:0] cnt_q;
    logic [2:0] cnt_d;

    // Next-state logic. The range test is done at 32 bits so that the
    // MODULUS=8 case does not collapse into a constant comparison.
    always_comb begin
        cnt_d = cnt_q;
        if (32'(cnt_q) >= 32'(MODULUS)) begin
            cnt_d = 3'd0;
        end else if (COUNT_DOWN) begin
            cnt_d = (cnt_q == 3'd0) ? MAX_COUNT : cnt_q - 3'd1;
        end else begin
            cnt_d = (cnt_q == MAX_COUNT) ? 3'd0 : cnt_q + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= RESET_VALUE;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign Q2 = cnt_q[2];
    assign Q1 = cnt_q[1];
    assign Q0 = cnt_q[0];

endmodule

// File: tb/tb_counter_3bit.sv
// Directed bench for counter_3bit: default up count, down count, modulus-5,
// and a down counter with a nonzero reset value, all sharing one clock.
module tb_counter_3bit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_up, rst_dn, rst_m5, rst_rv;
    logic up_q2, up_q1, up_q0;
    logic dn_q2, dn_q1, dn_q0;
    logic m5_q2, m5_q1, m5_q0;
    logic rv_q2, rv_q1, rv_q0;

    wire [2:0] up_v = {up_q2, up_q1, up_q0};
    wire [2:0] dn_v = {dn_q2, dn_q1, dn_q0};
    wire [2:0] m5_v = {m5_q2, m5_q1, m5_q0};
    wire [2:0] rv_v = {rv_q2, rv_q1, rv_q0};

    counter_3bit u_up (
        .clk(clk), .rst(rst_up), .Q2(up_q2), .Q1(up_q1), .Q0(up_q0)
    );

    counter_3bit #(.COUNT_DOWN(1'b1)) u_dn (
        .clk(clk), .rst(rst_dn), .Q2(dn_q2), .Q1(dn_q1), .Q0(dn_q0)
    );

    counter_3bit #(.MODULUS(5)) u_m5 (
        .clk(clk), .rst(rst_m5), .Q2(m5_q2), .Q1(m5_q1), .Q0(m5_q0)
    );

    counter_3bit #(.RESET_VALUE(3'd3), .MODULUS(6), .COUNT_DOWN(1'b1)) u_rv (
        .clk(clk), .rst(rst_rv), .Q2(rv_q2), .Q1(rv_q1), .Q0(rv_q0)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    logic [2:0] up_seq [9] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1};
    logic [2:0] dn_seq [9] = '{3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd7};
    logic [2:0] m5_seq [9] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
    logic [2:0] rv_seq [9] = '{3'd2, 3'd1, 3'd0, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};

    initial begin
        logic [2:0] model;

        rst_up = 1'b1; rst_dn = 1'b1; rst_m5 = 1'b1; rst_rv = 1'b1;

        // Reset edge at 5 ns; sample on the falling edge at 10 ns.
        @(negedge clk);
        check("reset_up", up_v, 3'd0);
        check("reset_dn", dn_v, 3'd0);
        check("reset_m5", m5_v, 3'd0);
        check("reset_rv", rv_v, 3'd3);
        rst_up = 1'b0; rst_dn = 1'b0; rst_m5 = 1'b0; rst_rv = 1'b0;

        #4;
        check("hold_at_14ns", up_v, 3'd0);

        // Edges at 15..95 ns: count, wrap, and step past the wrap.
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            $display("[TB] step %0d: up=%b dn=%b m5=%b rv=%b", i, up_v, dn_v, m5_v, rv_v);
            check($sformatf("up_step%0d", i), up_v, up_seq[i]);
            check($sformatf("dn_step%0d", i), dn_v, dn_seq[i]);
            check($sformatf("m5_step%0d", i), m5_v, m5_seq[i]);
            check($sformatf("rv_step%0d", i), rv_v, rv_seq[i]);
        end

        // Ten more edges (105..195 ns): 19 steps since reset.
        repeat (10) @(negedge clk);
        check("up_19_steps", up_v, 3'd3);
        check("dn_19_steps", dn_v, 3'd5);
        check("m5_19_steps", m5_v, 3'd4);
        check("rv_19_steps", rv_v, 3'd2);

        // Mid-run reset while the up counter reads 101.
        repeat (2) @(negedge clk);
        check("up_before_midreset", up_v, 3'd5);
        rst_up = 1'b1;
        @(negedge clk);
        check("up_midreset", up_v, 3'd0);
        rst_up = 1'b0;
        @(negedge clk);
        check("up_after_midreset", up_v, 3'd1);

        // A reset pulse that falls entirely between edges is ignored.
        #2 rst_up = 1'b1;
        #2 rst_up = 1'b0;
        @(negedge clk);
        check("up_glitch_ignored", up_v, 3'd2);

        // Reset the modulus-5 counter and track it against a reference model.
        rst_m5 = 1'b1;
        @(negedge clk);
        check("m5_rereset", m5_v, 3'd0);
        rst_m5 = 1'b0;
        model = 3'd0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            model = (model == 3'd4) ? 3'd0 : model + 3'd1;
            $display("[TB] m5 cycle %0d: observed=%b model=%b", i, m5_v, model);
            check($sformatf("m5_model%0d", i), m5_v, model);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
